uart_tx_drain: RTL and testbench
================================

// Module: uart_tx_drain
// PURPOSE
//   Serial UART transmitter that drains the synchronous FIFO through its empty/dequeue/data_out interface.
//   It pops one byte whenever the FIFO is non-empty and the line is idle.
//   It then serialises the byte as 8N1 (or 8N2): start bit, 8 data bits LSB first, stop bit(s).
//   Sits directly downstream of the memio TX FIFO and drives the board UART pin.
// PARAMETERS
//   CLKS_PER_BIT  868  clock cycles per bit period (100 MHz / 115200); legal range >= 2
//   STOP_BITS     1    number of stop bits; 1 or 2
//   FIFO_LATENCY  1    FIFO read latency: 1 = data valid the cycle after dequeue; 0 = data valid with dequeue
// PORTS
//   clock         in   1  system clock, all logic on posedge
//   reset         in   1  synchronous, active-high
//   fifo_empty    in   1  FIFO empty flag
//   fifo_dequeue  out  1  pop request to FIFO, combinational
//   fifo_data     in   8  FIFO read data
//   tx            out  1  serial line, idle high, registered
//   busy          out  1  high from the dequeue cycle through the last stop-bit cycle, registered-state derived
// BEHAVIOUR
//   Reset values
//   - tx=1, busy=0, fifo_dequeue=0.
//   - state=IDLE; baud counter, bit counter and shift register cleared.
//   Dequeue rule
//   - fifo_dequeue = (state==IDLE) && !fifo_empty && !reset.
//   - It is never high for more than 1 consecutive cycle.
//   - It is never high while fifo_empty=1.
//   States: IDLE -> FETCH -> START -> DATA -> STOP -> IDLE.
//   - IDLE: tx=1. On fifo_dequeue go to FETCH; FETCH is skipped when FIFO_LATENCY=0.
//     With FIFO_LATENCY=0, fifo_data is latched in this cycle instead of FETCH.
//   - FETCH: shift register <= fifo_data; go to START; tx still 1 this cycle.
//   - START: tx=0 for exactly CLKS_PER_BIT cycles.
//   - DATA: tx = shift[0] for CLKS_PER_BIT cycles, shift right, 8 bits total. Bit counter 0..7, exits DATA after bit 7.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//   Timing (FIFO_LATENCY=1)
//   - Dequeue in cycle n => tx low from cycle n+2.
//   - Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles.
//   - Back-to-back bytes: 2 extra idle-high cycles between frames (IDLE + FETCH); 1 cycle when FIFO_LATENCY=0.
//   Counter widths
//   - Baud counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 and wraps, producing a 1-cycle bit_done.
//   - Bit counter: 3 bits.
//   - No other arithmetic.
//   Boundary conditions
//   - fifo_empty rising while in START/DATA/STOP has no effect; the byte already latched completes.
//   - Reset mid-frame: tx=1 the cycle after reset is sampled high; the in-flight byte is dropped and not re-fetched.
//     The next frame starts only after reset deasserts and fifo_empty=0.
//   - fifo_data is sampled once only, in FETCH (or the IDLE dequeue cycle); later changes are ignored.
// STRUCTURE
//   Package uart_pkg
//   - typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} uart_tx_state_t
//   - localparam UART_DATA_BITS = 8.
//   Sub-module uart_baud_counter (params CLKS_PER_BIT)
//   - Inputs clock, reset, clear; output bit_done.
//   - Instantiated once; cleared on entry to START.
//   Top module holds the FSM, shift register, bit counter and tx register.
// TESTING (bench uses CLKS_PER_BIT=4, STOP_BITS=1, FIFO_LATENCY=1 unless stated)
//   1. Hold reset 5 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_dequeue=0 every cycle; 1 cycle after release, dequeue pulses once.
//   2. FIFO holds 0xA5, dequeue at cycle n -> tx low n+2..n+5; data 1,0,1,0,0,1,0,1 (4 cycles each, n+6..n+37); tx high n+38..n+41; busy=0 at n+42.
//   3. FIFO holds 0x00 then 0xFF -> exactly 2 dequeue pulses 42 cycles apart; tx high exactly 2 cycles between first stop bit and second start bit.
//   4. fifo_empty=1 for 200 cycles -> fifo_dequeue never asserts, tx constant 1, busy 0.
//   5. Assert reset 1 cycle during data bit 3 of 0x3C, fifo_empty=0 -> tx=1 next cycle; the new dequeue does not re-send 0x3C, next frame carries the next FIFO byte.
//   6. STOP_BITS=2, FIFO_LATENCY=0, byte 0x81 -> tx low the cycle after dequeue, stop high 8 cycles, frame length 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, pulsing bit_done on the last count.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic bit_done
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1/8N2 UART transmitter that pops bytes from a synchronous FIFO whenever the line is idle.
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_LATENCY = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fifo_empty,
   output logic       fifo_dequeue,
   input  logic [7:0] fifo_data,
   output logic       tx,
   output logic       busy
);

   localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

   uart_tx_state_t            state, state_next;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic                      tx_d;
   logic                      baud_clear;
   logic                      bit_done;

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clock    (clock),
      .reset    (reset),
      .clear    (baud_clear),
      .bit_done (bit_done)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx        <= 1'b1;
      end else begin
         state     <= state_next;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx        <= tx_d;
      end
   end

   always_comb begin
      state_next   = state;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      fifo_dequeue = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !reset) begin
               fifo_dequeue = 1'b1;
               // A zero-latency FIFO presents the byte alongside the pop, so skip FETCH.
               if (FIFO_LATENCY == 0) begin
                  shift_d    = fifo_data;
                  state_next = START;
               end else begin
                  state_next = FETCH;
               end
            end
         end
         FETCH: begin
            shift_d    = fifo_data;
            state_next = START;
         end
         START: begin
            if (bit_done) begin
               bit_cnt_d  = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_DATA_BIT) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            // The bit counter has wrapped to 0 leaving DATA and now counts stop bits.
            if (bit_done) begin
               if (bit_cnt_q == LAST_STOP_BIT) begin
                  state_next = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign baud_clear = (state_next == START) && (state != START);

   // tx is registered from the next-state view so the pin is glitch-free and aligned with state.
   always_comb begin
      case (state_next)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign busy = (state != IDLE) || fifo_dequeue;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: two instances (8N1 latency-1 and 8N2 latency-0) against a frame-waveform model.
module tb_uart_tx_drain;

   localparam int CPB   = 4;
   localparam int LOGSZ = 4096;

   logic       clock = 1'b0;
   logic       reset1 = 1'b1, reset2 = 1'b1;
   logic       fifo_empty1 = 1'b1, fifo_empty2 = 1'b1;
   logic [7:0] fifo_data1 = 8'h00, fifo_data2 = 8'h00;
   logic       fifo_dequeue1, fifo_dequeue2;
   logic       tx1, tx2, busy1, busy2;

   always #5 clock = ~clock;

   uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_LATENCY(1)) dut (
      .clock(clock), .reset(reset1), .fifo_empty(fifo_empty1), .fifo_dequeue(fifo_dequeue1),
      .fifo_data(fifo_data1), .tx(tx1), .busy(busy1));

   uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_LATENCY(0)) dut2 (
      .clock(clock), .reset(reset2), .fifo_empty(fifo_empty2), .fifo_dequeue(fifo_dequeue2),
      .fifo_data(fifo_data2), .tx(tx2), .busy(busy2));

   logic [7:0] fq1[$], fq2[$];
   logic [0:0] exp_q1[$], exp_q2[$];
   int         deq_cyc1[$], deq_cyc2[$];
   logic       tx_log1 [0:LOGSZ-1], busy_log1 [0:LOGSZ-1];
   logic       tx_log2 [0:LOGSZ-1], busy_log2 [0:LOGSZ-1];
   int         errors = 0, checks = 0, cyc = 0;
   logic       started = 1'b0;
   logic       deq_s1, deq_s2;
   logic       e_tx, e_deq, e_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Line level at offset idx within a frame: start slot, 8 data slots LSB first, then stop.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      int slot;
      slot = idx / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Latency-1 FIFO with registered read data.
   always begin
      @(negedge clock);
      deq_s1 = fifo_dequeue1;
      @(posedge clock);
      #2;
      if (deq_s1 && fq1.size() > 0) fifo_data1 = fq1.pop_front();
      fifo_empty1 = (fq1.size() == 0);
   end

   // Latency-0 (show-ahead) FIFO.
   always begin
      @(negedge clock);
      deq_s2 = fifo_dequeue2;
      @(posedge clock);
      #2;
      if (deq_s2 && fq2.size() > 0) void'(fq2.pop_front());
      fifo_empty2 = (fq2.size() == 0);
      fifo_data2  = (fq2.size() > 0) ? fq2[0] : 8'h00;
   end

   // Compare process: the model is a queue of expected line levels, one per future cycle.
   always @(negedge clock) begin
      if (started) begin
         e_tx   = (exp_q1.size() > 0) ? exp_q1[0] : 1'b1;
         e_deq  = (exp_q1.size() == 0) && !fifo_empty1 && !reset1;
         e_busy = (exp_q1.size() > 0) || e_deq;
         check("tx1", tx1, e_tx);
         check("dequeue1", fifo_dequeue1, e_deq);
         check("busy1", busy1, e_busy);
         if (cyc < LOGSZ) begin
            tx_log1[cyc]   = tx1;
            busy_log1[cyc] = busy1;
         end
         if (fifo_dequeue1) deq_cyc1.push_back(cyc);
         if (exp_q1.size() > 0) void'(exp_q1.pop_front());
         if (reset1) exp_q1.delete();
         else if (e_deq && fq1.size() > 0) begin
            exp_q1.push_back(1'b1);
            for (int i = 0; i < 10 * CPB; i++) exp_q1.push_back(frame_bit(fq1[0], i));
         end

         e_tx   = (exp_q2.size() > 0) ? exp_q2[0] : 1'b1;
         e_deq  = (exp_q2.size() == 0) && !fifo_empty2 && !reset2;
         e_busy = (exp_q2.size() > 0) || e_deq;
         check("tx2", tx2, e_tx);
         check("dequeue2", fifo_dequeue2, e_deq);
         check("busy2", busy2, e_busy);
         if (cyc < LOGSZ) begin
            tx_log2[cyc]   = tx2;
            busy_log2[cyc] = busy2;
         end
         if (fifo_dequeue2) deq_cyc2.push_back(cyc);
         if (exp_q2.size() > 0) void'(exp_q2.pop_front());
         if (reset2) exp_q2.delete();
         else if (e_deq && fq2.size() > 0) begin
            for (int i = 0; i < 11 * CPB; i++) exp_q2.push_back(frame_bit(fq2[0], i));
         end
      end
   end

   task automatic wait_deq1(input int base);
      for (int i = 0; i < 60 && deq_cyc1.size() <= base; i++) tick();
      check("deq1_timeout", (deq_cyc1.size() > base), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int         n, m, base, rel;
      logic [7:0] v;
      @(posedge clock);
      #1;
      started = 1'b1;

      // Reset held 5 cycles with a byte waiting, then the 0xA5 frame.
      fq1.push_back(8'hA5);
      repeat (4) tick();
      reset1 = 1'b0;
      rel = cyc;
      repeat (50) tick();
      check("t1_deq_count", deq_cyc1.size(), 1);
      n = (deq_cyc1.size() > 0) ? deq_cyc1[0] : 0;
      check("t1_deq_cycle", n, rel);
      check("t2_fetch_high", tx_log1[n+1], 1);
      check("t2_start_first", tx_log1[n+2], 0);
      check("t2_start_last", tx_log1[n+5], 0);
      v = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         check("t2_data_bit", tx_log1[n+6+4*k], v[k]);
         check("t2_data_bit_end", tx_log1[n+9+4*k], v[k]);
      end
      check("t2_stop_first", tx_log1[n+38], 1);
      check("t2_stop_last", tx_log1[n+41], 1);
      check("t2_busy_last", busy_log1[n+41], 1);
      check("t2_busy_done", busy_log1[n+42], 0);

      // Back-to-back 0x00 then 0xFF.
      base = deq_cyc1.size();
      fq1.push_back(8'h00);
      fq1.push_back(8'hFF);
      wait_deq1(base);
      repeat (100) tick();
      check("t3_deq_count", deq_cyc1.size() - base, 2);
      if (deq_cyc1.size() >= base + 2) begin
         n = deq_cyc1[base];
         check("t3_deq_gap", deq_cyc1[base+1] - n, 42);
         check("t3_stop_high", tx_log1[n+41], 1);
         check("t3_gap_idle", tx_log1[n+42], 1);
         check("t3_gap_fetch", tx_log1[n+43], 1);
         check("t3_second_start", tx_log1[n+44], 0);
      end

      // Empty FIFO for 200 cycles.
      base = deq_cyc1.size();
      repeat (200) tick();
      check("t4_no_deq", deq_cyc1.size() - base, 0);

      // Reset during data bit 3 of 0x3C, next byte 0x5A.
      base = deq_cyc1.size();
      fq1.push_back(8'h3C);
      fq1.push_back(8'h5A);
      wait_deq1(base);
      n = (deq_cyc1.size() > base) ? deq_cyc1[base] : cyc;
      for (int i = 0; i < 40 && cyc < n + 19; i++) tick();
      reset1 = 1'b1;
      tick();
      reset1 = 1'b0;
      repeat (60) tick();
      check("t5_tx_after_reset", tx_log1[n+20], 1);
      check("t5_deq_count", deq_cyc1.size() - base, 2);
      if (deq_cyc1.size() >= base + 2) begin
         m = deq_cyc1[base+1];
         check("t5_redeq_cycle", m, n + 20);
         check("t5_new_bit0", tx_log1[m+6], 0);
         check("t5_new_bit1", tx_log1[m+10], 1);
      end
      check("t5_fifo_drained", fq1.size(), 0);

      // 8N2 zero-latency instance, byte 0x81.
      reset2 = 1'b0;
      tick();
      fq2.push_back(8'h81);
      for (int i = 0; i < 20 && deq_cyc2.size() == 0; i++) tick();
      check("t6_deq_seen", deq_cyc2.size(), 1);
      m = (deq_cyc2.size() > 0) ? deq_cyc2[0] : cyc;
      repeat (60) tick();
      check("t6_deq_high", tx_log2[m], 1);
      check("t6_start", tx_log2[m+1], 0);
      check("t6_bit0", tx_log2[m+5], 1);
      check("t6_bit1", tx_log2[m+9], 0);
      check("t6_bit7", tx_log2[m+33], 1);
      check("t6_stop_first", tx_log2[m+37], 1);
      check("t6_stop_last", tx_log2[m+44], 1);
      check("t6_busy_last", busy_log2[m+44], 1);
      check("t6_busy_done", busy_log2[m+45], 0);

      // Random traffic and occasional resets on both instances.
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 15) == 0 && fq1.size() < 4) fq1.push_back(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 15) == 0 && fq2.size() < 4) fq2.push_back(8'($urandom_range(0, 255)));
         reset1 = ($urandom_range(0, 299) == 0);
         reset2 = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset1 = 1'b0;
      reset2 = 1'b0;
      repeat (250) tick();
      check("rand_fifo1_drained", fq1.size(), 0);
      check("rand_fifo2_drained", fq2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
